// File: rtl/counter_seq_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : counter_seq_ctrl_if
// Description : Control and status bundle between the counter sequencer
//               (slave) and whatever drives it (master). The master drives
//               the request inputs and returns the external counter value.
//               The master receives the counter enable/clear and status.
//   i_start/i_stop/i_mode   : start request, abort, 0=one-shot 1=periodic
//   i_target/i_prescale     : ticks per period (0 = 2**CNT_W), prescale-1
//   i_count                 : current value of the external counter
//   o_cnt_en/o_cnt_clr_n    : counter enable, active-low counter clear
//   o_busy/o_done           : activity flag, end-of-period pulse
//   o_period_cnt/o_state    : completed periods, FSM state
// Revision    : 1.0 - initial release
// ============================================================================
interface counter_seq_ctrl_if #(
    parameter int CNT_W = 8,
    parameter int PSC_W = 4
);
    logic             i_start;
    logic             i_stop;
    logic             i_mode;
    logic [CNT_W-1:0] i_target;
    logic [PSC_W-1:0] i_prescale;
    logic [CNT_W-1:0] i_count;
    logic             o_cnt_en;
    logic             o_cnt_clr_n;
    logic             o_busy;
    logic             o_done;
    logic [CNT_W-1:0] o_period_cnt;
    logic [1:0]       o_state;

    modport master (
        output i_start, i_stop, i_mode, i_target, i_prescale, i_count,
        input  o_cnt_en, o_cnt_clr_n, o_busy, o_done, o_period_cnt, o_state
    );

    modport slave (
        input  i_start, i_stop, i_mode, i_target, i_prescale, i_count,
        output o_cnt_en, o_cnt_clr_n, o_busy, o_done, o_period_cnt, o_state
    );
endinterface
`default_nettype wire

// File: rtl/counter_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : counter_seq_ctrl
// Description : Sequencer for an external enable-gated up-counter. Clears
//               the counter, gates its enable through a programmable
//               prescaler and detects the terminal count. One-shot or
//               periodic operation; o_done pulses at the end of each period.
// Ports       : i_clk      - clock
//               i_reset_n  - synchronous, active-low reset
//               bus        - counter_seq_ctrl_if.slave control/status bundle
// Revision    : 1.0 - initial release
// ============================================================================
module counter_seq_ctrl #(
    parameter int CNT_W = 8,
    parameter int PSC_W = 4
) (
    input  wire logic          i_clk,
    input  wire logic          i_reset_n,
    counter_seq_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] c_cnt_one = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [PSC_W-1:0] c_psc_one = {{(PSC_W-1){1'b0}}, 1'b1};

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_mode;
    logic [CNT_W-1:0] r_tgt;
    logic [PSC_W-1:0] r_psc_lat;
    logic [PSC_W-1:0] r_psc;
    logic [CNT_W-1:0] r_period_cnt;

    logic             w_tick;
    logic             w_final_tick;
    logic [CNT_W-1:0] w_tgt_m1;

    // A target of 0 wraps to all-ones here, so the final tick is reached
    // only after the counter has gone all the way round (2**CNT_W ticks).
    assign w_tgt_m1     = r_tgt - c_cnt_one;
    assign w_tick       = (r_state == RUN) && (r_psc == r_psc_lat);
    assign w_final_tick = w_tick && (bus.i_count == w_tgt_m1);

    // Next-state logic; stop outranks every other transition.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (!bus.i_stop && bus.i_start) begin
                    w_state_nxt = CLEAR;
                end
            end
            CLEAR: begin
                w_state_nxt = bus.i_stop ? IDLE : RUN;
            end
            RUN: begin
                if (bus.i_stop) begin
                    w_state_nxt = IDLE;
                end else if (w_final_tick) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                if (bus.i_stop || !r_mode) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_state_nxt = CLEAR;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_state      <= IDLE;
            r_mode       <= 1'b0;
            r_tgt        <= '0;
            r_psc_lat    <= '0;
            r_psc        <= '0;
            r_period_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                IDLE: begin
                    if (!bus.i_stop && bus.i_start) begin
                        r_mode       <= bus.i_mode;
                        r_period_cnt <= '0;
                    end
                end
                CLEAR: begin
                    // Settings are captured here so that changes made while
                    // running only apply from the next period onward.
                    r_tgt     <= bus.i_target;
                    r_psc_lat <= bus.i_prescale;
                    r_psc     <= '0;
                end
                RUN: begin
                    r_psc <= w_tick ? '0 : (r_psc + c_psc_one);
                    // Counted on entry to DONE so the new total is visible
                    // alongside the o_done pulse.
                    if (!bus.i_stop && w_final_tick) begin
                        r_period_cnt <= r_period_cnt + c_cnt_one;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.o_cnt_clr_n  = (r_state != CLEAR);
    assign bus.o_cnt_en     = w_tick;
    assign bus.o_done       = (r_state == DONE);
    assign bus.o_busy       = (r_state != IDLE);
    assign bus.o_period_cnt = r_period_cnt;
    assign bus.o_state      = r_state;

endmodule
`default_nettype wire

// File: tb/tb_counter_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_counter_seq_ctrl
// Description : Self-checking bench for counter_seq_ctrl. Models the
//               external 8-bit counter, drives directed scenarios and checks
//               every o_done pulse against a queue of expected completions.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_counter_seq_ctrl;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    counter_seq_ctrl_if #(.CNT_W(8), .PSC_W(4)) bus ();

    counter_seq_ctrl #(.CNT_W(8), .PSC_W(4)) dut (
        .i_clk     (clk),
        .i_reset_n (rst_n),
        .bus       (bus)
    );

    // External counter: synchronous clear from reset AND the sequencer clear.
    logic [7:0] cnt;
    always @(posedge clk) begin
        if (!(rst_n && bus.o_cnt_clr_n)) cnt <= 8'd0;
        else if (bus.o_cnt_en)           cnt <= cnt + 8'd1;
    end
    assign bus.i_count = cnt;

    int edge_cnt = 0;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    typedef struct {
        int         cyc;
        logic [7:0] cnt;
        logic [7:0] per;
    } exp_t;
    exp_t q[$];

    int n_cmp = 0;
    int n_err = 0;
    int en_cnt = 0;
    int base = 0;
    int e0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, edge_cnt);
        end
    endtask

    // Monitor: counts enable cycles and checks each o_done against the queue.
    always @(negedge clk) begin
        exp_t e;
        if (bus.o_cnt_en === 1'b1) en_cnt++;
        if (rst_n === 1'b1 && bus.o_done !== 1'b0) begin
            if (q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_done: got o_done=%b expected no pulse (edge %0d)",
                         bus.o_done, edge_cnt);
            end else begin
                e = q.pop_front();
                chk("done_cycle",  edge_cnt,         e.cyc);
                chk("done_count",  cnt,              e.cnt);
                chk("done_period", bus.o_period_cnt, e.per);
            end
        end
    end

    // Cycle c of a scenario is the cycle following edge c-1, where edge 0
    // is the edge that samples the start request.
    task automatic wait_cycle(input int c);
        while (edge_cnt - base < c) @(negedge clk);
    endtask

    task automatic launch(input logic mode, input logic [7:0] tgt, input logic [3:0] psc);
        bus.i_mode     = mode;
        bus.i_target   = tgt;
        bus.i_prescale = psc;
        bus.i_start    = 1'b1;
        base           = edge_cnt;
        @(negedge clk);
        bus.i_start    = 1'b0;
    endtask

    task automatic expect_done(input int c, input logic [7:0] cv, input logic [7:0] pv);
        exp_t e;
        e.cyc = base + c;
        e.cnt = cv;
        e.per = pv;
        q.push_back(e);
    endtask

    task automatic end_test(input string name);
        n_cmp++;
        if (q.size() != 0) begin
            n_err++;
            $display("FAIL %s_missing_done: got %0d pending expected 0", name, q.size());
            q.delete();
        end
    endtask

    initial begin
        rst_n          = 1'b0;
        bus.i_start    = 1'b0;
        bus.i_stop     = 1'b0;
        bus.i_mode     = 1'b0;
        bus.i_target   = 8'd0;
        bus.i_prescale = 4'd0;
        repeat (3) @(negedge clk);
        chk("rst_en",    bus.o_cnt_en,     0);
        chk("rst_clr_n", bus.o_cnt_clr_n,  1);
        chk("rst_busy",  bus.o_busy,       0);
        chk("rst_done",  bus.o_done,       0);
        chk("rst_per",   bus.o_period_cnt, 0);
        chk("rst_state", bus.o_state,      0);
        rst_n = 1'b1;
        @(negedge clk);

        // 1: one-shot, target 3, prescale 0 -> en cycles 2-4, done at 5.
        launch(1'b0, 8'd3, 4'd0);
        expect_done(5, 8'd3, 8'd1);
        e0 = en_cnt;
        chk("t1_clr_c1",   bus.o_cnt_clr_n, 0);
        chk("t1_state_c1", bus.o_state,     1);
        wait_cycle(2);
        chk("t1_en_c2",    bus.o_cnt_en,    1);
        wait_cycle(4);
        chk("t1_cnt_c4",   cnt,             2);
        wait_cycle(6);
        chk("t1_state_c6", bus.o_state,     0);
        chk("t1_en_total", en_cnt - e0,     3);
        end_test("t1");

        // 2: target 2, prescale 3 -> en at 5 and 9, done at 10.
        launch(1'b0, 8'd2, 4'd3);
        expect_done(10, 8'd2, 8'd1);
        e0 = en_cnt;
        wait_cycle(4);
        chk("t2_en_c4", bus.o_cnt_en, 0);
        wait_cycle(5);
        chk("t2_en_c5", bus.o_cnt_en, 1);
        wait_cycle(9);
        chk("t2_en_c9", bus.o_cnt_en, 1);
        wait_cycle(11);
        chk("t2_state_c11", bus.o_state, 0);
        chk("t2_en_total",  en_cnt - e0, 2);
        end_test("t2");

        // 3: periodic, target 2 -> done at 4, 8, 12; stop in the last DONE.
        launch(1'b1, 8'd2, 4'd0);
        expect_done(4,  8'd2, 8'd1);
        expect_done(8,  8'd2, 8'd2);
        expect_done(12, 8'd2, 8'd3);
        e0 = en_cnt;
        chk("t3_clr_c1", bus.o_cnt_clr_n, 0);
        wait_cycle(5);
        chk("t3_clr_c5", bus.o_cnt_clr_n, 0);
        wait_cycle(9);
        chk("t3_clr_c9", bus.o_cnt_clr_n, 0);
        wait_cycle(12);
        bus.i_stop = 1'b1;
        wait_cycle(13);
        bus.i_stop = 1'b0;
        chk("t3_state_c13", bus.o_state,      0);
        chk("t3_per_c13",   bus.o_period_cnt, 3);
        chk("t3_en_total",  en_cnt - e0,      6);
        end_test("t3");

        // 4: target 0 -> 256 ticks, counter wraps to 0, done at 258.
        launch(1'b0, 8'd0, 4'd0);
        expect_done(258, 8'd0, 8'd1);
        e0 = en_cnt;
        wait_cycle(257);
        chk("t4_cnt_c257", cnt, 255);
        wait_cycle(259);
        chk("t4_state",    bus.o_state, 0);
        chk("t4_en_total", en_cnt - e0, 256);
        end_test("t4");

        // 5: stop while the counter steps 4 -> 5; it must then hold 5.
        launch(1'b0, 8'd10, 4'd0);
        wait_cycle(6);
        chk("t5_cnt_c6", cnt, 4);
        bus.i_stop = 1'b1;
        wait_cycle(7);
        bus.i_stop = 1'b0;
        chk("t5_state_c7", bus.o_state,      0);
        chk("t5_cnt_c7",   cnt,              5);
        chk("t5_per_c7",   bus.o_period_cnt, 0);
        wait_cycle(9);
        chk("t5_cnt_c9",   cnt,              5);
        bus.i_start = 1'b1;
        bus.i_stop  = 1'b1;
        wait_cycle(10);
        bus.i_start = 1'b0;
        bus.i_stop  = 1'b0;
        chk("t5_both_state", bus.o_state, 0);
        chk("t5_both_busy",  bus.o_busy,  0);
        end_test("t5");

        // 6a: reset asserted mid-RUN of the second period.
        launch(1'b1, 8'd2, 4'd0);
        expect_done(4, 8'd2, 8'd1);
        wait_cycle(6);
        rst_n = 1'b0;
        wait_cycle(7);
        chk("t6_rst_en",    bus.o_cnt_en,     0);
        chk("t6_rst_clr_n", bus.o_cnt_clr_n,  1);
        chk("t6_rst_busy",  bus.o_busy,       0);
        chk("t6_rst_done",  bus.o_done,       0);
        chk("t6_rst_per",   bus.o_period_cnt, 0);
        chk("t6_rst_state", bus.o_state,      0);
        rst_n = 1'b1;
        wait_cycle(10);
        end_test("t6a");

        // 6b: start (with a new target) during DONE is ignored.
        launch(1'b0, 8'd3, 4'd0);
        expect_done(5, 8'd3, 8'd1);
        wait_cycle(5);
        bus.i_start  = 1'b1;
        bus.i_target = 8'd5;
        wait_cycle(6);
        bus.i_start  = 1'b0;
        chk("t6b_state_c6", bus.o_state, 0);
        wait_cycle(7);
        chk("t6b_state_c7", bus.o_state, 0);
        chk("t6b_busy_c7",  bus.o_busy,  0);
        end_test("t6b");

        // 6c: target changed mid-RUN applies from the next CLEAR only.
        launch(1'b1, 8'd2, 4'd0);
        expect_done(4,  8'd2, 8'd1);
        expect_done(10, 8'd4, 8'd2);
        wait_cycle(2);
        bus.i_target = 8'd4;
        wait_cycle(10);
        bus.i_stop = 1'b1;
        wait_cycle(11);
        bus.i_stop = 1'b0;
        chk("t6c_state_c11", bus.o_state, 0);
        wait_cycle(13);
        end_test("t6c");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
